// File: rtl/morse_tx_scheduler.sv
// morse_tx_scheduler
//   Sequencer for the morse letter datapath (7-way pattern mux feeding a
//   16-bit load/shift-left register). It round-robins between two letter
//   requesters and loads the chosen pattern. It then shifts it out at the
//   symbol rate and enforces an idle gap before the next letter.
//
// Ports
//   clock      in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   req_valid  in   [1:0] per-requester level request, held until acked
//   req_sel0   in   [2:0] letter select from requester 0
//   req_sel1   in   [2:0] letter select from requester 1
//   req_ack    out  [1:0] one-cycle acceptance pulse (visible during LOAD)
//   mux_sel    out  [2:0] pattern mux select, held from grant to next grant
//   sr_load_n  out  active-low parallel load strobe (low only in LOAD)
//   sr_shift   out  one-cycle shift-left enable, once per symbol in SEND
//   busy       out  high whenever the sequencer is not idle
//   done       out  one-cycle pulse on the first IDLE cycle after a letter
module morse_tx_scheduler #(
    parameter int unsigned TICK_DIV = 25000000,
    parameter int unsigned SYMS     = 16,
    parameter int unsigned GAP_SYMS = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req_valid,
    input  logic [2:0] req_sel0,
    input  logic [2:0] req_sel1,
    output logic [1:0] req_ack,
    output logic [2:0] mux_sel,
    output logic       sr_load_n,
    output logic       sr_shift,
    output logic       busy,
    output logic       done
);

    localparam int unsigned TickW = $clog2(TICK_DIV);
    localparam int unsigned SymMax = (SYMS > GAP_SYMS) ? SYMS : GAP_SYMS;
    localparam int unsigned SymW = $clog2(SymMax + 1);

    localparam logic [TickW-1:0] TickLoad = TickW'(TICK_DIV - 1);
    localparam logic [SymW-1:0]  SymLast  = SymW'(SYMS - 1);
    localparam logic [SymW-1:0]  GapLast  = SymW'((GAP_SYMS == 0) ? 0 : GAP_SYMS - 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StLoad = 2'd1;
    localparam logic [1:0] StSend = 2'd2;
    localparam logic [1:0] StGap  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
    logic [SymW-1:0]  sym_cnt_q, sym_cnt_d;
    logic             last_grant_q, last_grant_d;
    logic [2:0]       mux_sel_q, mux_sel_d;
    logic [1:0]       req_ack_q, req_ack_d;
    logic             done_q, done_d;

    logic tick_zero;
    logic grant;

    assign tick_zero = (tick_cnt_q == '0);

    // Single requester wins outright; on a tie the one not served last wins.
    assign grant = (req_valid == 2'b11) ? ~last_grant_q : req_valid[1];

    always_comb begin
        state_d      = state_q;
        tick_cnt_d   = tick_cnt_q;
        sym_cnt_d    = sym_cnt_q;
        last_grant_d = last_grant_q;
        mux_sel_d    = mux_sel_q;
        req_ack_d    = 2'b00;
        done_d       = 1'b0;

        case (state_q)
            StIdle: begin
                if (|req_valid) begin
                    mux_sel_d    = grant ? req_sel1 : req_sel0;
                    last_grant_d = grant;
                    req_ack_d    = grant ? 2'b10 : 2'b01;
                    state_d      = StLoad;
                end
            end
            StLoad: begin
                tick_cnt_d = TickLoad;
                sym_cnt_d  = '0;
                state_d    = StSend;
            end
            StSend: begin
                if (tick_zero) begin
                    tick_cnt_d = TickLoad;
                    if (sym_cnt_q == SymLast) begin
                        sym_cnt_d = '0;
                        if (GAP_SYMS == 0) begin
                            tick_cnt_d = '0;
                            done_d     = 1'b1;
                            state_d    = StIdle;
                        end else begin
                            state_d = StGap;
                        end
                    end else begin
                        sym_cnt_d = sym_cnt_q + SymW'(1);
                    end
                end else begin
                    tick_cnt_d = tick_cnt_q - TickW'(1);
                end
            end
            StGap: begin
                // Same symbol timing as SEND, but no shift strobe.
                if (tick_zero) begin
                    if (sym_cnt_q == GapLast) begin
                        tick_cnt_d = '0;
                        sym_cnt_d  = '0;
                        done_d     = 1'b1;
                        state_d    = StIdle;
                    end else begin
                        tick_cnt_d = TickLoad;
                        sym_cnt_d  = sym_cnt_q + SymW'(1);
                    end
                end else begin
                    tick_cnt_d = tick_cnt_q - TickW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StIdle;
            tick_cnt_q   <= '0;
            sym_cnt_q    <= '0;
            last_grant_q <= 1'b1;
            mux_sel_q    <= 3'd0;
            req_ack_q    <= 2'b00;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            sym_cnt_q    <= sym_cnt_d;
            last_grant_q <= last_grant_d;
            mux_sel_q    <= mux_sel_d;
            req_ack_q    <= req_ack_d;
            done_q       <= done_d;
        end
    end

    assign req_ack   = req_ack_q;
    assign mux_sel   = mux_sel_q;
    assign done      = done_q;
    assign busy      = (state_q != StIdle);
    assign sr_load_n = (state_q != StLoad);
    assign sr_shift  = (state_q == StSend) && tick_zero;

endmodule

// File: tb/tb_morse_tx_scheduler.sv
module tb_morse_tx_scheduler;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] req_valid = 2'b00;
    logic [2:0] req_sel0 = 3'd0;
    logic [2:0] req_sel1 = 3'd0;
    logic [1:0] req_ack;
    logic [2:0] mux_sel;
    logic       sr_load_n;
    logic       sr_shift;
    logic       busy;
    logic       done;

    int n_cmp = 0;
    int n_bad = 0;

    // Results of the most recent watch_letter run.
    int w_nshift, w_first, w_last, w_done, w_space, w_ack, w_load, w_mux, w_busy;

    morse_tx_scheduler #(
        .TICK_DIV(4),
        .SYMS    (16),
        .GAP_SYMS(3)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .req_valid(req_valid),
        .req_sel0 (req_sel0),
        .req_sel1 (req_sel1),
        .req_ack  (req_ack),
        .mux_sel  (mux_sel),
        .sr_load_n(sr_load_n),
        .sr_shift (sr_shift),
        .busy     (busy),
        .done     (done)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    // Called right after the LOAD cycle has been sampled (t = 0 is LOAD).
    task automatic watch_letter(input logic [2:0] exp_mux);
        int prev;
        w_nshift = 0; w_first = -1; w_last = -1; w_done = -1;
        w_space = 0; w_ack = 0; w_load = 0; w_mux = 0; w_busy = -1;
        prev = 0;
        for (int t = 1; t <= 120; t++) begin
            step();
            if (sr_shift) begin
                w_nshift++;
                if (w_first < 0) w_first = t;
                else if (t - prev != 4) w_space++;
                prev = t;
                w_last = t;
            end
            if (req_ack != 2'b00) w_ack++;
            if (!sr_load_n) w_load++;
            if (mux_sel != exp_mux) w_mux++;
            if (done) begin
                w_done = t;
                w_busy = busy;
                break;
            end
        end
    endtask

    task automatic check_letter(input string tag);
        check_eq({tag, ".nshift"}, w_nshift, 16);
        check_eq({tag, ".first_shift"}, w_first, 4);
        check_eq({tag, ".last_shift"}, w_last, 64);
        check_eq({tag, ".shift_spacing"}, w_space, 0);
        check_eq({tag, ".done_at"}, w_done, 77);
        check_eq({tag, ".busy_at_done"}, w_busy, 0);
        check_eq({tag, ".stray_ack"}, w_ack, 0);
        check_eq({tag, ".load_low"}, w_load, 0);
        check_eq({tag, ".mux_hold"}, w_mux, 0);
    endtask

    initial begin
        int a_busy, a_load, a_shift, a_ack, a_mux, a_done, cnt;

        // 1: quiet after reset
        do_reset();
        a_busy = 0; a_load = 0; a_shift = 0; a_ack = 0; a_mux = 0; a_done = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (busy !== 1'b0) a_busy++;
            if (sr_load_n !== 1'b1) a_load++;
            if (sr_shift !== 1'b0) a_shift++;
            if (req_ack !== 2'b00) a_ack++;
            if (mux_sel !== 3'd0) a_mux++;
            if (done !== 1'b0) a_done++;
        end
        check_eq("t1.busy", a_busy, 0);
        check_eq("t1.load_n", a_load, 0);
        check_eq("t1.shift", a_shift, 0);
        check_eq("t1.ack", a_ack, 0);
        check_eq("t1.mux_sel", a_mux, 0);
        check_eq("t1.done", a_done, 0);

        // 2: single letter from requester 0
        req_sel0 = 3'd3;
        req_valid = 2'b01;
        step();
        check_eq("t2.ack", req_ack, 2'b01);
        check_eq("t2.load_n", sr_load_n, 0);
        check_eq("t2.mux_sel", mux_sel, 3);
        check_eq("t2.busy", busy, 1);
        req_valid = 2'b00;
        watch_letter(3'd3);
        check_letter("t2");
        step();
        check_eq("t2.done_width", done, 0);

        // 3: both requesting continuously, alternating grants
        do_reset();
        req_sel0 = 3'd2;
        req_sel1 = 3'd5;
        req_valid = 2'b11;
        step();
        for (int k = 0; k < 4; k++) begin
            check_eq($sformatf("t3.ack%0d", k), req_ack, (k % 2 == 0) ? 2'b01 : 2'b10);
            check_eq($sformatf("t3.mux%0d", k), mux_sel, (k % 2 == 0) ? 2 : 5);
            check_eq($sformatf("t3.load_n%0d", k), sr_load_n, 0);
            watch_letter((k % 2 == 0) ? 3'd2 : 3'd5);
            check_letter($sformatf("t3.l%0d", k));
            if (k < 3) step();
        end
        req_valid = 2'b00;
        step();
        check_eq("t3.final_ack", req_ack, 2'b00);
        check_eq("t3.final_busy", busy, 0);

        // 4: requester 1 toggling during SEND is ignored until IDLE
        do_reset();
        req_sel0 = 3'd1;
        req_sel1 = 3'd6;
        req_valid = 2'b01;
        step();
        check_eq("t4.ack0", req_ack, 2'b01);
        req_valid = 2'b00;
        a_ack = 0;
        a_done = -1;
        for (int t = 1; t <= 120; t++) begin
            req_valid = (t < 70 && (t % 4) >= 2) ? 2'b10 : 2'b00;
            step();
            if (req_ack !== 2'b00) a_ack++;
            if (done) begin
                a_done = t;
                break;
            end
        end
        check_eq("t4.no_ack_busy", a_ack, 0);
        check_eq("t4.done_at", a_done, 77);
        req_valid = 2'b10;
        step();
        check_eq("t4.ack1", req_ack, 2'b10);
        check_eq("t4.mux_sel", mux_sel, 6);
        check_eq("t4.load_n", sr_load_n, 0);
        req_valid = 2'b00;
        watch_letter(3'd6);
        check_eq("t4.l2_done_at", w_done, 77);
        step();
        check_eq("t4.no_ack_idle", req_ack, 2'b00);
        check_eq("t4.idle_busy", busy, 0);

        // 5: reset in the middle of a letter
        req_sel0 = 3'd4;
        req_valid = 2'b01;
        step();
        check_eq("t5.ack", req_ack, 2'b01);
        req_valid = 2'b00;
        cnt = 0;
        for (int t = 0; t < 100; t++) begin
            step();
            if (sr_shift) cnt++;
            if (cnt == 7) break;
        end
        check_eq("t5.reached_7", cnt, 7);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_eq("t5.busy", busy, 0);
        check_eq("t5.shift", sr_shift, 0);
        check_eq("t5.mux_sel", mux_sel, 0);
        check_eq("t5.load_n", sr_load_n, 1);
        a_shift = 0; a_done = 0; a_busy = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (sr_shift) a_shift++;
            if (done) a_done++;
            if (busy) a_busy++;
        end
        check_eq("t5.no_shift", a_shift, 0);
        check_eq("t5.no_done", a_done, 0);
        check_eq("t5.stay_idle", a_busy, 0);
        req_sel0 = 3'd7;
        req_valid = 2'b01;
        step();
        check_eq("t5.fresh_ack", req_ack, 2'b01);
        check_eq("t5.fresh_mux", mux_sel, 7);
        req_valid = 2'b00;
        watch_letter(3'd7);
        check_letter("t5");

        // 6: request held across reset
        reset = 1'b1;
        req_sel0 = 3'd5;
        req_valid = 2'b01;
        a_ack = 0; a_busy = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (req_ack !== 2'b00) a_ack++;
            if (busy) a_busy++;
        end
        check_eq("t6.no_ack_in_reset", a_ack, 0);
        check_eq("t6.no_busy_in_reset", a_busy, 0);
        reset = 1'b0;
        step();
        check_eq("t6.ack", req_ack, 2'b01);
        check_eq("t6.load_n", sr_load_n, 0);
        check_eq("t6.mux_sel", mux_sel, 5);
        req_valid = 2'b00;
        watch_letter(3'd5);
        check_eq("t6.done_at", w_done, 77);
        check_eq("t6.nshift", w_nshift, 16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/morse_tx_scheduler.md
Name: morse_tx_scheduler

Overview:
- Controller that sequences the morse letter datapath: the 7-way letter pattern mux feeding the 16-bit load/shift-left register.
- Arbitrates between two letter requesters (round-robin), selects the pattern, and issues the register's active-low load strobe.
- Generates the symbol-rate shift strobe internally and inserts an inter-letter gap.
- Reports busy/done and acknowledges each accepted request.

Parameters:
- TICK_DIV, 25000000, clock cycles per symbol (0.5 s at 50 MHz); legal range >= 2.
- SYMS, 16, shift strobes issued per letter (the register width).
- GAP_SYMS, 3, symbol periods of enforced idle after a letter, with no shifting.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  2  per-requester letter request, level; held until acked.
- req_sel0  in  3  letter select from requester 0.
- req_sel1  in  3  letter select from requester 1.
- req_ack  out  2  one-cycle acceptance pulse per requester.
- mux_sel  out  3  select to the pattern mux.
- sr_load_n  out  1  active-low parallel load to the shift register.
- sr_shift  out  1  one-cycle shift-left enable to the shift register.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse when a letter plus its gap completes.

Behaviour:
- Clock and reset: one clock, `clock`. Reset is synchronous and active-high on `reset`, sampled on the rising edge; it overrides all other inputs.
- Reset values:
  - state = IDLE.
  - req_ack = 0, sr_shift = 0, done = 0, busy = 0.
  - sr_load_n = 1, mux_sel = 0.
  - tick_cnt = 0, sym_cnt = 0.
  - last_grant = 1, so requester 0 wins the first tie.
- Outputs: all outputs are registered or decoded from registered state only. No combinational path exists from req_* to any output.
- States: IDLE -> LOAD -> SEND -> GAP -> IDLE.
- IDLE:
  - If any req_valid bit is set, grant one requester. With a single requester, grant it. With both, grant the one != last_grant.
  - On the grant edge: latch its select into mux_sel, update last_grant, register req_ack[grant]=1 (visible for exactly the LOAD cycle), and go to LOAD.
  - The requester must drop or change req_valid on the cycle after the ack.
- LOAD (exactly 1 cycle):
  - sr_load_n = 0; mux_sel stable.
  - tick_cnt <= TICK_DIV-1, sym_cnt <= 0; go to SEND.
- SEND:
  - tick_cnt decrements each cycle.
  - When tick_cnt == 0: sr_shift = 1 that cycle, tick_cnt <= TICK_DIV-1, sym_cnt++.
  - On the shift with sym_cnt == SYMS-1: go to GAP with tick_cnt <= TICK_DIV-1 and sym_cnt <= 0.
  - Each pattern bit is therefore visible on the register output for exactly TICK_DIV cycles.
- GAP:
  - Same tick timing as SEND, but sr_shift stays 0 and the line stays low (zeros shifted in).
  - After GAP_SYMS ticks: go to IDLE and register done = 1 for the first IDLE cycle.
  - If GAP_SYMS = 0: SEND goes directly to IDLE with done.
- Latency and throughput:
  - Request accepted in IDLE -> first bit on the line 2 edges later (grant edge, LOAD edge).
  - Total busy time per letter = 1 + (SYMS + GAP_SYMS) * TICK_DIV cycles.
  - A new grant may occur in the same IDLE cycle in which done is high (back-to-back letters).
- Held outputs:
  - mux_sel holds its value from the grant until the next grant.
  - sr_load_n is 1 in every state except LOAD.
- Requests outside IDLE: req_valid changes in LOAD, SEND or GAP are ignored and never acked. Pending requests are evaluated on return to IDLE.
- Reset mid-letter: state returns to IDLE with all counters cleared, and no done pulse is issued. The shift register contents are not cleared by this block; its own reset handles that.
- Counter widths: tick_cnt is wide enough for TICK_DIV-1; sym_cnt is wide enough for max(SYMS, GAP_SYMS). No wrap-around occurs in legal operation.

Test Plan:
All scenarios use TICK_DIV=4, SYMS=16, GAP_SYMS=3.
1. Reset held 2 cycles then released, no requests -> busy=0, sr_load_n=1, sr_shift=0, req_ack=00, mux_sel=0 indefinitely.
2. req_valid=01, req_sel0=3 -> req_ack=01 and sr_load_n=0 in the same single cycle with mux_sel=3. Then exactly 16 sr_shift pulses spaced 4 cycles apart, the first 4 cycles after LOAD. Then 12 idle cycles, then a done pulse 77 cycles after the LOAD cycle.
3. req_valid=11 held continuously, req_sel0=2, req_sel1=5 -> grants alternate 0,1,0,1 (first grant to 0), with mux_sel 2,5,2,5. Each new LOAD follows its done pulse with no extra idle cycle.
4. req_valid=10 toggled on and off during SEND -> no ack until IDLE. Ack to requester 1 occurs on the done cycle only if valid is high then.
5. reset asserted for 1 cycle at the 7th sr_shift -> next cycle busy=0, no further sr_shift, no done pulse. A fresh request afterwards completes normally in 77 cycles.
6. Request during reset: req_valid=01 held while reset=1 -> no ack until the first cycle after reset deasserts, with the grant on that edge.
